riscv_operand_stage: RTL and testbench

Parametrised successor to the op2 mux: selects the ALU second operand, resolves rs2 against a configurable number of forwarding sources, and registers the result into a one-entry valid/ready pipeline stage (ID→EX boundary). While the stage is stalled, the held operand keeps tracking late forwarding writes so it never goes stale. A saturating counter reports how many accepted instructions needed a forwarded rs2.

---
 rtl/riscv_operand_stage.sv | 148 ++++++++++++++
 tb/tb_riscv_operand_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_operand_stage.sv
// riscv_operand_stage
//   ID->EX operand stage: selects the ALU second operand, resolves rs2
//   against NUM_FWD forwarding sources (index 0 youngest, highest priority)
//   and registers the result in a one-entry valid/ready slot. While stalled,
//   the held rs2 keeps tracking forwarding writes. fwd_count saturates and
//   counts accepted instructions whose rs2 came from a forwarding source.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   op2_sel                  operand select (riscv_constants::op2_sel_t)
//   rs2_addr, rs2_data       rs2 address and register-file value
//   imm_{i,s,j}_sext         sign-extended immediates
//   fwd_valid/addr/data      packed forwarding sources
//   flush                    drop held and incoming instruction
//   out_valid/out_ready      downstream handshake
//   dout, store_data         registered op2 and resolved rs2
//   fwd_count                saturating forwarded-accept count

package riscv_constants;
  typedef logic [2:0] op2_sel_t;
  localparam op2_sel_t OP2_RS2 = 3'd0;
  localparam op2_sel_t OP2_IMI = 3'd1;
  localparam op2_sel_t OP2_IMS = 3'd2;
  localparam op2_sel_t OP2_IMJ = 3'd3;
endpackage

module riscv_operand_stage
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH    = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 2,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  op2_sel_t                          op2_sel,
  input  logic [REG_ADDR_WIDTH-1:0]         rs2_addr,
  input  logic [WORD_LENGTH-1:0]            rs2_data,
  input  logic [WORD_LENGTH-1:0]            imm_i_sext,
  input  logic [WORD_LENGTH-1:0]            imm_s_sext,
  input  logic [WORD_LENGTH-1:0]            imm_j_sext,
  input  logic [NUM_FWD-1:0]                fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr,
  input  logic [NUM_FWD*WORD_LENGTH-1:0]    fwd_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_LENGTH-1:0]            dout,
  output logic [WORD_LENGTH-1:0]            store_data,
  output logic [COUNT_WIDTH-1:0]            fwd_count
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e                    r_state, w_state_nxt;
  op2_sel_t                  r_sel;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [WORD_LENGTH-1:0]    r_dout, r_sd;
  logic [COUNT_WIDTH-1:0]    r_cnt;

  logic                      w_in_hit, w_hd_hit;
  logic [WORD_LENGTH-1:0]    w_in_fwd, w_hd_fwd, w_rs2_res, w_op2;
  logic                      w_accept, w_hold;

  // Walk sources from oldest to youngest so the lowest matching index
  // is the last write and wins. x0 never matches.
  always_comb begin
    w_in_hit = 1'b0;
    w_in_fwd = '0;
    w_hd_hit = 1'b0;
    w_hd_fwd = '0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (fwd_valid[k] && (rs2_addr != '0) &&
          (fwd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs2_addr)) begin
        w_in_hit = 1'b1;
        w_in_fwd = fwd_data[k*WORD_LENGTH +: WORD_LENGTH];
      end
      if (fwd_valid[k] && (r_addr != '0) &&
          (fwd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == r_addr)) begin
        w_hd_hit = 1'b1;
        w_hd_fwd = fwd_data[k*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

  assign w_rs2_res = w_in_hit ? w_in_fwd : rs2_data;

  always_comb begin
    w_op2 = '0;
    case (op2_sel)
      OP2_RS2: w_op2 = w_rs2_res;
      OP2_IMI: w_op2 = imm_i_sext;
      OP2_IMS: w_op2 = imm_s_sext;
      OP2_IMJ: w_op2 = imm_j_sext;
      default: w_op2 = '0;
    endcase
  end

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready && !flush;
  // Stalled with a valid entry: accept is impossible here since in_ready=0.
  assign w_hold    = out_valid && !out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL: begin
        if (flush)                       w_state_nxt = S_EMPTY;
        else if (out_ready && !w_accept) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_sd   <= '0;
      r_sel  <= OP2_RS2;
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_dout <= w_op2;
      r_sd   <= w_rs2_res;
      r_sel  <= op2_sel;
      r_addr <= rs2_addr;
      if (w_in_hit && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end else if (w_hold && w_hd_hit) begin
      r_sd <= w_hd_fwd;
      if (r_sel == OP2_RS2) r_dout <= w_hd_fwd;
    end
  end

  assign dout       = r_dout;
  assign store_data = r_sd;
  assign fwd_count  = r_cnt;

endmodule

// File: tb/tb_riscv_operand_stage.sv
// tb_riscv_operand_stage
//   Directed scenarios followed by random traffic, checked against a
//   transaction-level model of the stage (one optional held entry).
module tb_riscv_operand_stage;
  import riscv_constants::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
  op2_sel_t         op2_sel;
  logic [AW-1:0]    rs2_addr;
  logic [W-1:0]     rs2_data, imm_i_sext, imm_s_sext, imm_j_sext;
  logic [NF-1:0]    fwd_valid;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*W-1:0]  fwd_data;
  logic [W-1:0]     dout, store_data;
  logic [CW-1:0]    fwd_count;

  riscv_operand_stage #(.WORD_LENGTH(W), .REG_ADDR_WIDTH(AW), .NUM_FWD(NF),
                        .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op2_sel(op2_sel), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .imm_i_sext(imm_i_sext), .imm_s_sext(imm_s_sext), .imm_j_sext(imm_j_sext),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .store_data(store_data), .fwd_count(fwd_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model state: the single held entry.
  bit          m_v;
  logic [W-1:0] m_dout, m_sd;
  op2_sel_t    m_sel;
  logic [AW-1:0] m_addr;
  int          m_cnt;

  // First matching source in priority order (0 first).
  task automatic lookup(input logic [AW-1:0] a, output bit hit, output logic [W-1:0] d);
    hit = 0;
    d   = '0;
    if (a == 0) return;
    for (int k = 0; k < NF; k++)
      if (fwd_valid[k] && fwd_addr[k*AW +: AW] == a) begin
        hit = 1;
        d   = fwd_data[k*W +: W];
        return;
      end
  endtask

  task automatic step();
    bit hit;
    logic [W-1:0] fd, rs;
    bit acc;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_v || out_ready)});
    if (rst) begin
      m_v = 0; m_dout = 0; m_sd = 0; m_sel = OP2_RS2; m_addr = 0; m_cnt = 0;
    end else if (flush) begin
      m_v = 0;
    end else begin
      acc = in_valid && (!m_v || out_ready);
      if (acc) begin
        lookup(rs2_addr, hit, fd);
        rs = hit ? fd : rs2_data;
        if      (op2_sel == OP2_RS2) m_dout = rs;
        else if (op2_sel == OP2_IMI) m_dout = imm_i_sext;
        else if (op2_sel == OP2_IMS) m_dout = imm_s_sext;
        else if (op2_sel == OP2_IMJ) m_dout = imm_j_sext;
        else                         m_dout = 0;
        m_sd = rs; m_sel = op2_sel; m_addr = rs2_addr; m_v = 1;
        if (hit && m_cnt < CMAX) m_cnt++;
      end else if (m_v && out_ready) begin
        m_v = 0;
      end else if (m_v) begin
        lookup(m_addr, hit, fd);
        if (hit) begin
          m_sd = fd;
          if (m_sel == OP2_RS2) m_dout = fd;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
    chk("dout", dout, m_dout);
    chk("store_data", store_data, m_sd);
    chk("fwd_count", {30'b0, fwd_count}, m_cnt);
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; flush = 0; out_ready = 1; op2_sel = OP2_RS2;
    rs2_addr = 0; rs2_data = 0; imm_i_sext = 0; imm_s_sext = 0; imm_j_sext = 0;
    fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic put_fwd(input int k, input logic [AW-1:0] a, input logic [W-1:0] d);
    fwd_valid[k] = 1'b1;
    fwd_addr[k*AW +: AW] = a;
    fwd_data[k*W +: W]   = d;
  endtask

  initial begin
    idle_inputs();
    m_v = 0; m_dout = 0; m_sd = 0; m_sel = OP2_RS2; m_addr = 0; m_cnt = 0;
    @(posedge clk); #1;

    // Reset
    rst = 1; step();
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_dout", dout, 0);
    rst = 0;

    // Immediate capture
    in_valid = 1; op2_sel = OP2_IMI; imm_i_sext = 32'hFFFF_FFF0; step();
    chk("imi_dout", dout, 32'hFFFF_FFF0);
    chk("imi_cnt", {30'b0, fwd_count}, 0);

    // Forwarding priority
    op2_sel = OP2_RS2; rs2_addr = 5; rs2_data = 32'h11;
    put_fwd(0, 5, 32'hAA); put_fwd(1, 5, 32'hBB); step();
    chk("prio_dout", dout, 32'hAA);
    chk("prio_sd", store_data, 32'hAA);
    chk("prio_cnt", {30'b0, fwd_count}, 1);

    // x0 never forwards
    rs2_addr = 0; rs2_data = 0; fwd_valid = '1; fwd_addr = '0; step();
    chk("x0_dout", dout, 0);
    chk("x0_cnt", {30'b0, fwd_count}, 1);

    // Stall with held update on an immediate op
    fwd_valid = 0; op2_sel = OP2_IMS; imm_s_sext = 32'h40; rs2_addr = 7; rs2_data = 32'h1;
    step();
    in_valid = 0; out_ready = 0; put_fwd(1, 7, 32'h99); step();
    chk("stall_dout", dout, 32'h40);
    chk("stall_sd", store_data, 32'h99);
    chk("stall_rdy", {31'b0, in_ready}, 0);
    fwd_valid = 0; out_ready = 1; step();
    chk("drain_valid", {31'b0, out_valid}, 0);

    // Flush during a stall with a new input present
    in_valid = 1; op2_sel = OP2_IMJ; imm_j_sext = 32'h1234; step();
    out_ready = 0; imm_j_sext = 32'h5678; flush = 1; put_fwd(0, 7, 32'h77); step();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_dout", dout, 32'h1234);
    flush = 0; in_valid = 0; fwd_valid = 0; out_ready = 1; step();

    // Saturation: five forwarded accepts with a 2-bit counter
    in_valid = 1; op2_sel = OP2_RS2; rs2_addr = 3; put_fwd(1, 3, 32'hC0DE);
    repeat (5) step();
    chk("sat_cnt", {30'b0, fwd_count}, CMAX);

    // Reset in the middle of a stall
    out_ready = 0; step();
    rst = 1; step();
    chk("midrst_dout", dout, 0);
    chk("midrst_cnt", {30'b0, fwd_count}, 0);
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      op2_sel    = op2_sel_t'($urandom_range(0, 7));
      rs2_addr   = AW'($urandom_range(0, 7));
      rs2_data   = $urandom;
      imm_i_sext = $urandom; imm_s_sext = $urandom; imm_j_sext = $urandom;
      for (int k = 0; k < NF; k++) begin
        fwd_valid[k] = $urandom_range(0, 1);
        fwd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_data[k*W +: W]   = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
